st_pkt_rr_arb: RTL and testbench
================================

Name: st_pkt_rr_arb

Overview:
- Packet-level round-robin arbiter that shares one axis-like output stream among CHNL_NUM axis-like requesters.
- Typically drives the input side of a one-cycle register slice (valid/ready/last/user/data).
- A grant is held for a whole packet, from the first beat to the beat with tlast, so beats from different channels never interleave.
- Reports which channel owns the current beat.

Parameters:
- CHNL_NUM, 4, number of requesting channels (2..16).
- TUSER_WIDTH, 128, per-beat user width.
- TDATA_WIDTH, 256, per-beat data width.
- CHNL_W, derived: clog2(CHNL_NUM), minimum 1; width of channel index.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axis_tvalid  in  CHNL_NUM  per-channel valid.
- s_axis_tlast  in  CHNL_NUM  per-channel last.
- s_axis_tuser  in  CHNL_NUM*TUSER_WIDTH  channel i at [i*TUSER_WIDTH +: TUSER_WIDTH].
- s_axis_tdata  in  CHNL_NUM*TDATA_WIDTH  channel i at [i*TDATA_WIDTH +: TDATA_WIDTH].
- s_axis_tready  out  CHNL_NUM  per-channel ready.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  output last.
- m_axis_tuser  out  TUSER_WIDTH  output user.
- m_axis_tdata  out  TDATA_WIDTH  output data.
- m_axis_tready  in  1  downstream ready.
- m_axis_tid  out  CHNL_W  index of the granted channel.

Behaviour:
- FSM states: IDLE, BUSY. Registers: state, grant (CHNL_W), last_grant (CHNL_W).
- Reset values:
  - state = IDLE, grant = 0, last_grant = CHNL_NUM-1, so channel 0 wins first.
  - All outputs 0; s_axis_tready = 0.
- IDLE:
  - s_axis_tready = 0 and m_axis_tvalid = 0.
  - If any s_axis_tvalid is high, the winner is the first valid channel scanning last_grant+1, last_grant+2, … modulo CHNL_NUM.
  - On that edge: grant <= winner, state <= BUSY.
  - No valid channel: stay in IDLE.
- BUSY:
  - m_axis_tvalid = s_axis_tvalid[grant]; m_axis_tlast/tuser/tdata = the slices of channel grant.
  - m_axis_tid = grant.
  - s_axis_tready[i] = (i == grant) & m_axis_tready; all other readies are 0.
  - A beat transfers when m_axis_tvalid & m_axis_tready. The path is combinational, zero latency.
  - On a transfer with tlast = 1: last_grant <= grant, state <= IDLE.
  - A granted channel that drops valid mid-packet keeps the grant; there is no timeout.
- Output gating:
  - When m_axis_tvalid = 0, m_axis_tlast, m_axis_tuser and m_axis_tdata are forced to 0.
  - m_axis_tid = grant in BUSY, 0 in IDLE.
- Throughput: each packet costs one arbitration cycle in IDLE, then one beat per cycle while the downstream is ready.
  - A 1-beat packet therefore occupies 2 cycles.
- Fairness: a channel that keeps tvalid high is served within CHNL_NUM packets.
  - Non-requesting channels are skipped with no idle cycles.
- Boundary conditions:
  - tlast beat while m_axis_tready = 0: no transfer, remain in BUSY.
  - Wrap-around: last_grant = CHNL_NUM-1 scans from channel 0.
  - Non-power-of-2 CHNL_NUM: indices ≥ CHNL_NUM are never selected.
  - A new request arriving while BUSY has no effect until the return to IDLE.
  - Reset asserted mid-packet: immediate return to reset values. The partial packet is truncated, and recovering it is upstream's responsibility.
- Inputs are assumed to hold per axis rules: valid with payload stable until ready. This is not checked in RTL; it is a bench assertion.

Decomposition:
- Shared package holds:
  - State encodings ST_IDLE = 1'b0, ST_BUSY = 1'b1.
  - A clog2 function.
- The `TD delay macro comes from the existing common include.
- One sub-module: st_rr_sel, purely combinational.
  - Inputs: req[CHNL_NUM], last_grant.
  - Outputs: winner index, any_req.
  - Implemented as a doubled-request rotate and priority encode.
- The FSM and payload mux live in the top module.

Test Plan:
- Reset, then ch0 and ch2 each send a 1-beat packet, both valid at cycle 0, m_axis_tready = 1 → ch0 beat out at cycle 1 (tid = 0), ch2 beat at cycle 3 (tid = 2); 4 cycles total.
- All 4 channels continuously valid, 3-beat packets, tready = 1 → tid sequence 0,0,0,1,1,1,2,2,2,3,3,3,0…; exactly one idle cycle between packets.
- Ch1 granted with a 4-beat packet while ch0 requests at beat 2 → ch0 ready stays 0 and no ch0 beat interleaves; ch0 is granted only after ch1's tlast transfers.
- Backpressure: m_axis_tready toggles 1,0,0,1 during the tlast beat of ch3 → FSM stays BUSY until the beat transfers, then the next winner scan starts from ch0.
- Granted ch2 drops tvalid for 5 cycles mid-packet → m_axis_tvalid = 0 and tdata/tuser/tlast = 0, grant stays at 2; resume completes the packet.
- rst_n asserted asynchronously mid-packet on ch1 → all readies and m_axis_tvalid drop to 0 before the next edge; after release, ch0 wins first if requesting.

Source files
------------

// File: rtl/st_pkt_rr_arb_pkg.sv
// Shared definitions for the packet round-robin arbiter: FSM state encoding
// and the channel-index width helper.
package st_pkt_rr_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Width of an index able to address n channels, never less than 1 bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/st_rr_sel.sv
// Combinational round-robin selector: first requesting channel after last_grant,
// found by rotating a doubled request vector and priority-encoding the result.
module st_rr_sel
    import st_pkt_rr_arb_pkg::*;
#(
    parameter int unsigned CHNL_NUM = 4,
    parameter int unsigned CHNL_W   = clog2_min1(CHNL_NUM)
) (
    input  logic [CHNL_NUM-1:0] req,
    input  logic [CHNL_W-1:0]   last_grant,
    output logic [CHNL_W-1:0]   winner,
    output logic                any_req
);

    logic [2*CHNL_NUM-1:0] req2;
    logic [CHNL_NUM-1:0]   rot;
    int unsigned           start;
    int unsigned           offs;
    int unsigned           idx;

    always_comb begin
        req2  = {req, req};
        // start reaches CHNL_NUM when last_grant is the top channel; the doubled
        // vector makes that shift equivalent to a rotate by zero.
        start = 32'(last_grant) + 32'd1;
        rot   = CHNL_NUM'(req2 >> start);
        offs  = 0;
        for (int unsigned k = CHNL_NUM; k > 0; k--) begin
            if (rot[k-1]) begin
                offs = k - 1;
            end
        end
        idx = start + offs;
        if (idx >= CHNL_NUM) begin
            idx = idx - CHNL_NUM;
        end
        winner  = CHNL_W'(idx);
        any_req = |req;
    end

endmodule

// File: rtl/st_pkt_rr_arb.sv
// Packet-level round-robin arbiter: holds a grant from first beat to tlast so
// channels never interleave, with a zero-latency payload mux to one output stream.
module st_pkt_rr_arb
    import st_pkt_rr_arb_pkg::*;
#(
    parameter int unsigned CHNL_NUM    = 4,
    parameter int unsigned TUSER_WIDTH = 128,
    parameter int unsigned TDATA_WIDTH = 256,
    parameter int unsigned CHNL_W      = clog2_min1(CHNL_NUM)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CHNL_NUM-1:0]             s_axis_tvalid,
    input  logic [CHNL_NUM-1:0]             s_axis_tlast,
    input  logic [CHNL_NUM*TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [CHNL_NUM*TDATA_WIDTH-1:0] s_axis_tdata,
    output logic [CHNL_NUM-1:0]             s_axis_tready,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    output logic [TUSER_WIDTH-1:0]          m_axis_tuser,
    output logic [TDATA_WIDTH-1:0]          m_axis_tdata,
    input  logic                            m_axis_tready,
    output logic [CHNL_W-1:0]               m_axis_tid
);

    state_t                  state;
    logic [CHNL_W-1:0]       grant;
    logic [CHNL_W-1:0]       last_grant;
    logic [CHNL_W-1:0]       winner;
    logic                    any_req;
    logic                    busy;
    logic                    sel_valid;
    logic                    sel_last;
    logic [TUSER_WIDTH-1:0]  sel_user;
    logic [TDATA_WIDTH-1:0]  sel_data;

    st_rr_sel #(
        .CHNL_NUM (CHNL_NUM),
        .CHNL_W   (CHNL_W)
    ) u_sel (
        .req        (s_axis_tvalid),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= CHNL_W'(CHNL_NUM - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant <= winner;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Loop-compare mux keeps indices beyond CHNL_NUM unselectable for any CHNL_NUM.
    always_comb begin
        busy      = (state == ST_BUSY);
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = '0;
        sel_data  = '0;
        for (int unsigned i = 0; i < CHNL_NUM; i++) begin
            if (CHNL_W'(i) == grant) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_user  = s_axis_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
                sel_data  = s_axis_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
            end
        end

        m_axis_tvalid = busy & sel_valid;
        m_axis_tlast  = m_axis_tvalid & sel_last;
        m_axis_tuser  = m_axis_tvalid ? sel_user : '0;
        m_axis_tdata  = m_axis_tvalid ? sel_data : '0;
        m_axis_tid    = busy ? grant : '0;

        for (int unsigned i = 0; i < CHNL_NUM; i++) begin
            s_axis_tready[i] = busy && (CHNL_W'(i) == grant) && m_axis_tready;
        end
    end

endmodule

// File: tb/tb_st_pkt_rr_arb.sv
// Directed bench for st_pkt_rr_arb: arbitration order, packet hold, backpressure,
// mid-packet valid gaps and asynchronous reset.
module tb_st_pkt_rr_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned UW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    v;
    logic [N-1:0]    l;
    logic [UW-1:0]   u [N];
    logic [DW-1:0]   d [N];
    logic [N*UW-1:0] s_user;
    logic [N*DW-1:0] s_data;
    logic [N-1:0]    s_ready;
    logic            m_valid;
    logic            m_last;
    logic [UW-1:0]   m_user;
    logic [DW-1:0]   m_data;
    logic            m_ready;
    logic [CW-1:0]   m_id;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            s_user[i*UW +: UW] = u[i];
            s_data[i*DW +: DW] = d[i];
        end
    end

    st_pkt_rr_arb #(
        .CHNL_NUM    (N),
        .TUSER_WIDTH (UW),
        .TDATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tvalid (v),
        .s_axis_tlast  (l),
        .s_axis_tuser  (s_user),
        .s_axis_tdata  (s_data),
        .s_axis_tready (s_ready),
        .m_axis_tvalid (m_valid),
        .m_axis_tlast  (m_last),
        .m_axis_tuser  (m_user),
        .m_axis_tdata  (m_data),
        .m_axis_tready (m_ready),
        .m_axis_tid    (m_id)
    );

    function automatic logic [UW-1:0] pu(int c, int b);
        return UW'(c * 16 + b);
    endfunction

    function automatic logic [DW-1:0] pd(int c, int b);
        return DW'(32'hA000 + c * 256 + b);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int c, input int b, input logic last);
        v[c] = 1'b1;
        l[c] = last;
        u[c] = pu(c, b);
        d[c] = pd(c, b);
    endtask

    task automatic drop(input int c);
        v[c] = 1'b0;
        l[c] = 1'b0;
        u[c] = '0;
        d[c] = '0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input int c, input int b,
                            input logic elast, input logic [N-1:0] erdy);
        #1;
        chk({tag, ".valid"}, 32'(m_valid), 32'd1);
        chk({tag, ".last"},  32'(m_last),  32'(elast));
        chk({tag, ".user"},  32'(m_user),  32'(pu(c, b)));
        chk({tag, ".data"},  32'(m_data),  32'(pd(c, b)));
        chk({tag, ".tid"},   32'(m_id),    32'(c));
        chk({tag, ".ready"}, 32'(s_ready), 32'(erdy));
    endtask

    task automatic chk_gap(input string tag, input int eid, input logic [N-1:0] erdy);
        #1;
        chk({tag, ".valid"}, 32'(m_valid), 32'd0);
        chk({tag, ".last"},  32'(m_last),  32'd0);
        chk({tag, ".user"},  32'(m_user),  32'd0);
        chk({tag, ".data"},  32'(m_data),  32'd0);
        chk({tag, ".tid"},   32'(m_id),    32'(eid));
        chk({tag, ".ready"}, 32'(s_ready), 32'(erdy));
    endtask

    task automatic do_reset;
        rst_n   = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < N; c++) drop(c);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        m_ready = 1'b0;
        for (int c = 0; c < N; c++) drop(c);
        chk_gap("rst0", 0, 4'b0000);
        v       = '1;
        l       = '1;
        m_ready = 1'b1;
        tick();
        chk_gap("rst_hold", 0, 4'b0000);

        // Two 1-beat packets on ch0 and ch2 presented together
        do_reset();
        drive(0, 0, 1'b1);
        drive(2, 0, 1'b1);
        chk_gap("t1_arb0", 0, 4'b0000);
        tick();
        chk_beat("t1_ch0", 0, 0, 1'b1, 4'b0001);
        tick();
        drop(0);
        chk_gap("t1_arb1", 0, 4'b0000);
        tick();
        chk_beat("t1_ch2", 2, 0, 1'b1, 4'b0100);
        tick();
        drop(2);
        chk_gap("t1_done", 0, 4'b0000);

        // All channels streaming 3-beat packets: one arbitration cycle per packet
        do_reset();
        for (int c = 0; c < N; c++) drive(c, 0, 1'b0);
        for (int p = 0; p < 5; p++) begin
            chk_gap($sformatf("t2_arb%0d", p), 0, 4'b0000);
            tick();
            for (int b = 0; b < 3; b++) begin
                chk_beat($sformatf("t2_p%0d_b%0d", p, b), p % 4, b, (b == 2),
                         4'b0001 << (p % 4));
                tick();
                drive(p % 4, (b + 1) % 3, ((b + 1) % 3) == 2);
            end
        end
        for (int c = 0; c < N; c++) drop(c);

        // ch0 requests in the middle of a ch1 packet and must wait for tlast
        do_reset();
        drive(1, 0, 1'b0);
        chk_gap("t3_arb0", 0, 4'b0000);
        tick();
        chk_beat("t3_b0", 1, 0, 1'b0, 4'b0010);
        tick();
        drive(1, 1, 1'b0);
        chk_beat("t3_b1", 1, 1, 1'b0, 4'b0010);
        tick();
        drive(1, 2, 1'b0);
        drive(0, 0, 1'b1);
        chk_beat("t3_b2", 1, 2, 1'b0, 4'b0010);
        tick();
        drive(1, 3, 1'b1);
        chk_beat("t3_b3", 1, 3, 1'b1, 4'b0010);
        tick();
        drop(1);
        chk_gap("t3_arb1", 0, 4'b0000);
        tick();
        chk_beat("t3_ch0", 0, 0, 1'b1, 4'b0001);
        tick();
        drop(0);
        chk_gap("t3_done", 0, 4'b0000);

        // Backpressure on ch3's tlast beat, then wrap-around scan from ch0
        do_reset();
        drive(3, 0, 1'b0);
        chk_gap("t4_arb0", 0, 4'b0000);
        tick();
        chk_beat("t4_b0", 3, 0, 1'b0, 4'b1000);
        tick();
        drive(3, 1, 1'b1);
        drive(0, 0, 1'b1);
        drive(2, 0, 1'b1);
        m_ready = 1'b0;
        chk_beat("t4_bp0", 3, 1, 1'b1, 4'b0000);
        tick();
        chk_beat("t4_bp1", 3, 1, 1'b1, 4'b0000);
        tick();
        m_ready = 1'b1;
        chk_beat("t4_go", 3, 1, 1'b1, 4'b1000);
        tick();
        drop(3);
        chk_gap("t4_arb1", 0, 4'b0000);
        tick();
        chk_beat("t4_wrap", 0, 0, 1'b1, 4'b0001);
        tick();
        drop(0);
        chk_gap("t4_arb2", 0, 4'b0000);
        tick();
        chk_beat("t4_ch2", 2, 0, 1'b1, 4'b0100);
        tick();
        drop(2);
        chk_gap("t4_done", 0, 4'b0000);

        // Granted ch2 drops valid for 5 cycles mid-packet; stale payload must be gated
        do_reset();
        drive(2, 0, 1'b0);
        chk_gap("t5_arb", 0, 4'b0000);
        tick();
        chk_beat("t5_b0", 2, 0, 1'b0, 4'b0100);
        tick();
        for (int i = 0; i < 5; i++) begin
            v[2] = 1'b0;
            l[2] = 1'b1;
            u[2] = 8'hEE;
            d[2] = 16'hDEAD;
            chk_gap($sformatf("t5_hole%0d", i), 2, 4'b0100);
            tick();
        end
        drive(2, 1, 1'b0);
        chk_beat("t5_b1", 2, 1, 1'b0, 4'b0100);
        tick();
        drive(2, 2, 1'b1);
        chk_beat("t5_b2", 2, 2, 1'b1, 4'b0100);
        tick();
        drop(2);
        chk_gap("t5_done", 0, 4'b0000);

        // Asynchronous reset in the middle of a ch1 packet
        do_reset();
        drive(1, 0, 1'b0);
        chk_gap("t6_arb0", 0, 4'b0000);
        tick();
        chk_beat("t6_b0", 1, 0, 1'b0, 4'b0010);
        tick();
        drive(1, 1, 1'b0);
        drive(0, 0, 1'b1);
        chk_beat("t6_b1", 1, 1, 1'b0, 4'b0010);
        #2;
        rst_n = 1'b0;
        chk_gap("t6_rst", 0, 4'b0000);
        tick();
        rst_n = 1'b1;
        chk_gap("t6_rel", 0, 4'b0000);
        tick();
        chk_beat("t6_ch0", 0, 0, 1'b1, 4'b0001);
        tick();
        drop(0);
        drop(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
